// File: rtl/label_pack_pkg.sv
// ---------------------------------------------------------------------------
// label_pack_pkg
// Shared constants for the label packer: labels per output word, byte-index
// width, the bit layout of one word-FIFO entry, and the helper that turns the
// index of the final written byte into a tkeep mask.
// ---------------------------------------------------------------------------
package label_pack_pkg;

    localparam int LABELS_PER_WORD = 8;
    localparam int IDX_W           = 3;

    // Word-FIFO entry layout: {last, keep[7:0], data[63:0]}
    localparam int DATA_LSB = 0;
    localparam int KEEP_LSB = 64;
    localparam int LAST_BIT = 72;
    localparam int ENTRY_W  = 73;

    // Bytes 0..idx are valid, which gives keep = 2^(idx+1) - 1.
    function automatic logic [LABELS_PER_WORD-1:0] keep_from_idx(input logic [IDX_W-1:0] idx);
        logic [LABELS_PER_WORD-1:0] keep;
        keep = '0;
        for (int i = 0; i < LABELS_PER_WORD; i++) begin
            keep[i] = (IDX_W'(i) <= idx);
        end
        return keep;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
// Generic synchronous FIFO with separate read/write pointers and an
// occupancy count. The head entry is read combinationally, so it is the
// registered memory word and there is no same-cycle fall-through.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise the entry is dropped and `drop` pulses for that cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   push       write request
//   push_data  entry to write
//   pop        read request (ignored when empty)
//   head       entry at the read pointer
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   drop       push refused this cycle because the FIFO was full
// ---------------------------------------------------------------------------
module word_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic do_push;
    logic do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/label_pack.sv
// ---------------------------------------------------------------------------
// label_pack
// Packs the classifier's 8-bit label stream (valid/last, never stalled) into
// 64-bit AXI-Stream words, eight labels per word, first label in bits [7:0].
// A word is flushed when its 8th byte arrives or when s_tlast is seen; a
// short final word carries zeros in unwritten bytes and a trimmed tkeep.
// Flushed words go through a word FIFO that soaks up DMA backpressure; a
// word that finds the FIFO full (with no pop that cycle) is dropped and the
// sticky overflow flag is raised.
//
// Ports:
//   aclk      clock, rising edge
//   areset    asynchronous active-high reset
//   s_tdata   label in
//   s_tvalid  label valid (always accepted)
//   s_tlast   last label of the frame, qualified by s_tvalid
//   m_tdata   packed word out (0 while m_tvalid low)
//   m_tkeep   byte enables (0 while m_tvalid low)
//   m_tvalid  FIFO not empty
//   m_tready  downstream ready
//   m_tlast   word closes the frame (0 while m_tvalid low)
//   overflow  sticky: a word was dropped, cleared only by areset
// ---------------------------------------------------------------------------
module label_pack
    import label_pack_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [IN_WIDTH-1:0]    s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic [OUT_WIDTH-1:0]   m_tdata,
    output logic [OUT_WIDTH/8-1:0] m_tkeep,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   overflow
);

    localparam int KEEP_W = OUT_WIDTH / 8;

    logic [IDX_W-1:0]     idx;
    logic [OUT_WIDTH-1:0] asm_word;
    logic [OUT_WIDTH-1:0] asm_next;
    logic                 flush;
    logic [ENTRY_W-1:0]   push_entry;

    logic [ENTRY_W-1:0]   head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic                 pop;

    // Current word with the incoming label merged into lane idx.
    always_comb begin
        asm_next = asm_word;
        for (int i = 0; i < LABELS_PER_WORD; i++) begin
            if (IDX_W'(i) == idx) begin
                asm_next[i*IN_WIDTH +: IN_WIDTH] = s_tdata;
            end
        end
    end

    assign flush = s_tvalid && ((idx == IDX_W'(LABELS_PER_WORD - 1)) || s_tlast);

    // The merged word is pushed directly, so an 8th-byte-plus-last beat
    // yields one full word and never leaves an empty trailer behind.
    always_comb begin
        push_entry                            = '0;
        push_entry[DATA_LSB +: OUT_WIDTH]     = asm_next;
        push_entry[KEEP_LSB +: KEEP_W]        = keep_from_idx(idx);
        push_entry[LAST_BIT]                  = s_tlast;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx      <= '0;
            asm_word <= '0;
        end else if (s_tvalid) begin
            if (flush) begin
                idx      <= '0;
                asm_word <= '0;
            end else begin
                idx      <= idx + 1'b1;
                asm_word <= asm_next;
            end
        end
    end

    assign pop = m_tvalid && m_tready;

    word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (flush),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end
    end

    // Head fields are masked while empty so stale memory never shows.
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? head[DATA_LSB +: OUT_WIDTH] : '0;
    assign m_tkeep  = m_tvalid ? head[KEEP_LSB +: KEEP_W]    : '0;
    assign m_tlast  = m_tvalid ? head[LAST_BIT]              : 1'b0;

    // Sanity tie-off: fifo_full is only consumed inside the FIFO's own
    // drop/accept logic, but keep it observable for anyone probing the top.
    logic fifo_full_seen;
    assign fifo_full_seen = fifo_full;

endmodule

// File: tb/tb_label_pack.sv
module tb_label_pack;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        overflow;

    always #5 aclk = ~aclk;

    label_pack #(
        .IN_WIDTH   (8),
        .OUT_WIDTH  (64),
        .FIFO_DEPTH (16)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .overflow (overflow)
    );

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        l;
        logic        r;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [7:0] d, input logic v, input logic l, input logic r,
                       input logic ev, input logic [63:0] ed, input logic [7:0] ek, input logic el);
        vec_t x;
        x.d = d; x.v = v; x.l = l; x.r = r;
        x.ev = ev; x.ed = ed; x.ek = ek; x.el = el;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic ev, input logic [63:0] ed,
                         input logic [7:0] ek, input logic el, input logic eo);
        n_vec++;
        if ({m_tvalid, m_tlast, m_tkeep, m_tdata, overflow} !== {ev, el, ek, ed, eo}) begin
            n_err++;
            $display("FAIL %s: got v=%0b l=%0b k=%02h d=%016h ovf=%0b, want v=%0b l=%0b k=%02h d=%016h ovf=%0b",
                     name, m_tvalid, m_tlast, m_tkeep, m_tdata, overflow, ev, el, ek, ed, eo);
        end
    endtask

    // Inputs change at a falling edge; returns at the next falling edge,
    // half a cycle after the rising edge that sampled them.
    task automatic drive(input logic [7:0] d, input logic v, input logic l, input logic r);
        s_tdata  = d;
        s_tvalid = v;
        s_tlast  = l;
        m_tready = r;
        @(negedge aclk);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    // Full word w holds labels w*8 .. w*8+7, first in the low byte.
    function automatic logic [63:0] word_of(input int w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = 8'(w*8 + b);
        end
        return r;
    endfunction

    initial begin
        areset   = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // ---------------- vector table ----------------
        // Eight labels, no last
        for (int k = 1; k <= 7; k++) add(8'(k), 1, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h08, 1, 0, 1, 1, 64'h0807060504030201, 8'hFF, 0);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);
        // Eleven labels, last on the 11th
        for (int k = 0; k <= 6; k++) add(8'(8'h11 + k), 1, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h18, 1, 0, 1, 1, 64'h1817161514131211, 8'hFF, 0);
        add(8'h19, 1, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h1A, 1, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h1B, 1, 1, 1, 1, 64'h00000000001B1A19, 8'h07, 1);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);
        // Last on the 8th label: one word, no trailer
        for (int k = 0; k <= 6; k++) add(8'(8'h21 + k), 1, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h28, 1, 1, 1, 1, 64'h2827262524232221, 8'hFF, 1);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);
        // Word held stable under backpressure, then popped
        for (int k = 0; k <= 6; k++) add(8'(8'h31 + k), 1, 0, 0, 0, 64'h0, 8'h00, 0);
        add(8'h38, 1, 0, 0, 1, 64'h3837363534333231, 8'hFF, 0);
        add(8'h00, 0, 0, 0, 1, 64'h3837363534333231, 8'hFF, 0);
        add(8'h00, 0, 0, 0, 1, 64'h3837363534333231, 8'hFF, 0);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);
        // Single-label frame right after
        add(8'h5A, 1, 1, 1, 1, 64'h000000000000005A, 8'h01, 1);
        add(8'h00, 0, 0, 1, 0, 64'h0, 8'h00, 0);

        // ---------------- reset state ----------------
        @(negedge aclk);
        check("reset_held", 0, 64'h0, 8'h00, 0, 0);
        areset = 1'b0;
        @(negedge aclk);
        check("reset_released", 0, 64'h0, 8'h00, 0, 0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ek, vecs[i].el, 1'b0);
        end

        // ---------------- overflow: 17 words, ready low ----------------
        do_reset();
        for (int j = 0; j < 136; j++) begin
            drive(8'(j), 1, 0, 0);
            if (j == 127) check("ovf_fifo_full_no_flag", 1, word_of(0), 8'hFF, 0, 0);
            if (j == 134) check("ovf_before_17th", 1, word_of(0), 8'hFF, 0, 0);
            if (j == 135) check("ovf_on_17th", 1, word_of(0), 8'hFF, 0, 1);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_drain%0d", i), 1, word_of(i), 8'hFF, 0, 1);
            @(negedge aclk);
        end
        check("ovf_drain_empty", 0, 64'h0, 8'h00, 0, 1);

        // ---------------- full FIFO, pop coincides with flush ----------------
        do_reset();
        for (int j = 0; j < 135; j++) drive(8'(j), 1, 0, 0);
        drive(8'd135, 1, 0, 1);
        s_tvalid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("same_cycle_drain%0d", i), 1, word_of(i), 8'hFF, 0, 0);
            @(negedge aclk);
        end
        check("same_cycle_empty", 0, 64'h0, 8'h00, 0, 0);

        // ---------------- async reset mid-fill, words queued ----------------
        do_reset();
        for (int j = 0; j < 29; j++) drive(8'(j), 1, 0, 0);
        check("pre_reset_queued", 1, word_of(0), 8'hFF, 0, 0);
        #2 areset = 1'b1;
        #1 check("async_reset_outputs", 0, 64'h0, 8'h00, 0, 0);
        @(negedge aclk);
        areset = 1'b0;
        for (int k = 0; k < 7; k++) drive(8'(8'hA0 + k), 1, 0, 1);
        check("post_reset_idx0", 0, 64'h0, 8'h00, 0, 0);
        drive(8'hA7, 1, 0, 1);
        check("post_reset_word", 1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 0, 0);
        drive(8'h00, 0, 0, 1);
        check("post_reset_empty", 0, 64'h0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
